// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sap_pkg
// Description : Shared SAP-1 constants: T-states, opcodes and control-word bits
// Revision    : 1.0  initial release
// ============================================================================
package sap_pkg;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word, MSB first: cp ep low_lm low_ce low_li low_ei low_la ea su eu low_lb low_lo
    localparam int CW_W  = 12;
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    localparam logic [CW_W-1:0] CW_IDLE = 12'b0011_1110_0011;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_HALT = 3'd1,
        SEL_LDA  = 3'd2,
        SEL_ADD  = 3'd3,
        SEL_SUB  = 3'd4,
        SEL_OUT  = 3'd5
    } op_sel_t;

    // Drive one control to its active level regardless of its polarity.
    function automatic logic [CW_W-1:0] cw_on(input logic [CW_W-1:0] cw, input int idx);
        logic [CW_W-1:0] r;
        r      = cw;
        r[idx] = ~CW_IDLE[idx];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_counter.sv
`default_nettype none
// ============================================================================
// Module      : ring_counter
// Description : One-hot rotating T-state ring with synchronous reset and hold
// Revision    : 1.0  initial release
// ============================================================================
module ring_counter #(
    parameter int NUM_T = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             freeze,
    output logic [NUM_T-1:0] t_state
);

    logic [NUM_T-1:0] r_ring;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_ring <= {{(NUM_T-1){1'b0}}, 1'b1};
        end else if (!freeze) begin
            r_ring <= {r_ring[NUM_T-2:0], r_ring[NUM_T-1]};
        end
    end

    assign t_state = r_ring;

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : SAP-1 T-state controller: halt flag plus control-word matrix
// Revision    : 1.0  initial release
// ============================================================================
module control_sequencer
    import sap_pkg::*;
#(
    parameter int NUM_T = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             lda,
    input  logic             add,
    input  logic             sub,
    input  logic             out,
    input  logic             low_halt,
    output logic             cp,
    output logic             ep,
    output logic             ea,
    output logic             su,
    output logic             eu,
    output logic             low_lm,
    output logic             low_ce,
    output logic             low_li,
    output logic             low_ei,
    output logic             low_la,
    output logic             low_lb,
    output logic             low_lo,
    output logic [NUM_T-1:0] t_state,
    output logic             halted
);

    logic            r_halted;
    logic            w_halt_req;
    logic            w_freeze;
    op_sel_t         w_sel;
    logic [CW_W-1:0] w_cw;

    // The IR only holds the current opcode from T4 on, so HLT is sampled there.
    assign w_halt_req = (t_state == T4) && !low_halt;
    assign w_freeze   = r_halted || w_halt_req;

    ring_counter #(
        .NUM_T (NUM_T)
    ) u_ring (
        .clk     (clk),
        .clr     (clr),
        .freeze  (w_freeze),
        .t_state (t_state)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_halted <= 1'b0;
        end else if (w_halt_req) begin
            r_halted <= 1'b1;
        end
    end

    always_comb begin
        w_sel = SEL_NONE;
        if (!low_halt)  w_sel = SEL_HALT;
        else if (lda)   w_sel = SEL_LDA;
        else if (add)   w_sel = SEL_ADD;
        else if (sub)   w_sel = SEL_SUB;
        else if (out)   w_sel = SEL_OUT;
    end

    always_comb begin
        w_cw = CW_IDLE;
        if (!r_halted) begin
            case (t_state)
                T1: w_cw = cw_on(cw_on(CW_IDLE, CW_EP), CW_LM);
                T2: w_cw = cw_on(CW_IDLE, CW_CP);
                T3: w_cw = cw_on(cw_on(CW_IDLE, CW_CE), CW_LI);
                T4: begin
                    if (w_sel == SEL_LDA || w_sel == SEL_ADD || w_sel == SEL_SUB)
                        w_cw = cw_on(cw_on(CW_IDLE, CW_EI), CW_LM);
                    else if (w_sel == SEL_OUT)
                        w_cw = cw_on(cw_on(CW_IDLE, CW_EA), CW_LO);
                end
                T5: begin
                    if (w_sel == SEL_LDA)
                        w_cw = cw_on(cw_on(CW_IDLE, CW_CE), CW_LA);
                    else if (w_sel == SEL_ADD || w_sel == SEL_SUB)
                        w_cw = cw_on(cw_on(CW_IDLE, CW_CE), CW_LB);
                end
                T6: begin
                    if (w_sel == SEL_ADD)
                        w_cw = cw_on(cw_on(CW_IDLE, CW_EU), CW_LA);
                    else if (w_sel == SEL_SUB)
                        w_cw = cw_on(cw_on(cw_on(CW_IDLE, CW_EU), CW_LA), CW_SU);
                end
                default: w_cw = CW_IDLE;
            endcase
        end
    end

    assign cp     = w_cw[CW_CP];
    assign ep     = w_cw[CW_EP];
    assign low_lm = w_cw[CW_LM];
    assign low_ce = w_cw[CW_CE];
    assign low_li = w_cw[CW_LI];
    assign low_ei = w_cw[CW_EI];
    assign low_la = w_cw[CW_LA];
    assign ea     = w_cw[CW_EA];
    assign su     = w_cw[CW_SU];
    assign eu     = w_cw[CW_EU];
    assign low_lb = w_cw[CW_LB];
    assign low_lo = w_cw[CW_LO];
    assign halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Table-driven, hand-written and randomized checks of control_sequencer
// Revision    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

    // Asserted-control mask: bit set means the control is at its active level.
    localparam int A_CP = 0,  A_EP = 1,  A_LM = 2,  A_CE = 3,  A_LI = 4,  A_EI = 5;
    localparam int A_LA = 6,  A_EA = 7,  A_SU = 8,  A_EU = 9,  A_LB = 10, A_LO = 11;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       lda = 1'b0, add = 1'b0, sub = 1'b0, out = 1'b0, low_halt = 1'b1;
    logic       cp, ep, ea, su, eu;
    logic       low_lm, low_ce, low_li, low_ei, low_la, low_lb, low_lo;
    logic [5:0] t_state;
    logic       halted;

    int checks   = 0;
    int failures = 0;

    int m_step = 0;
    bit m_halt = 1'b0;

    control_sequencer #(.NUM_T(6)) dut (
        .clk(clk), .clr(clr), .lda(lda), .add(add), .sub(sub), .out(out),
        .low_halt(low_halt), .cp(cp), .ep(ep), .ea(ea), .su(su), .eu(eu),
        .low_lm(low_lm), .low_ce(low_ce), .low_li(low_li), .low_ei(low_ei),
        .low_la(low_la), .low_lb(low_lb), .low_lo(low_lo),
        .t_state(t_state), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       clr, lda, add, sub, out, low_halt;
        logic [5:0] exp_t;
        logic       exp_h;
        logic [11:0] exp_act;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] m(input int a, input int b = -1, input int c = -1);
        logic [11:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        return r;
    endfunction

    function automatic logic [11:0] dut_act();
        return {~low_lo, ~low_lb, eu, su, ea, ~low_la, ~low_ei, ~low_li,
                ~low_ce, ~low_lm, ep, cp};
    endfunction

    // Reference: instruction step 0..5 plus a halted flag, decoded from the opcode rules.
    function automatic logic [11:0] model_act(input int step, input bit h, input logic l_lda,
            input logic l_add, input logic l_sub, input logic l_out, input logic l_lh);
        string op;
        if (h) return '0;
        if (step == 0) return m(A_EP, A_LM);
        if (step == 1) return m(A_CP);
        if (step == 2) return m(A_CE, A_LI);
        op = !l_lh ? "HLT" : l_lda ? "LDA" : l_add ? "ADD" : l_sub ? "SUB" : l_out ? "OUT" : "NOP";
        if (op == "LDA" || op == "ADD" || op == "SUB") begin
            if (step == 3) return m(A_EI, A_LM);
            if (step == 4) return (op == "LDA") ? m(A_CE, A_LA) : m(A_CE, A_LB);
            if (op == "ADD") return m(A_EU, A_LA);
            if (op == "SUB") return m(A_EU, A_LA, A_SU);
            return '0;
        end
        if (op == "OUT" && step == 3) return m(A_EA, A_LO);
        return '0;
    endfunction

    task automatic check(input string name, input logic [5:0] et, input logic eh,
                         input logic [11:0] ea_);
        checks++;
        if (t_state !== et) begin
            failures++;
            $display("FAIL %s t_state actual=%b required=%b", name, t_state, et);
        end
        checks++;
        if (halted !== eh) begin
            failures++;
            $display("FAIL %s halted actual=%b required=%b", name, halted, eh);
        end
        checks++;
        if (dut_act() !== ea_) begin
            failures++;
            $display("FAIL %s controls actual=%b required=%b", name, dut_act(), ea_);
        end
    endtask

    task automatic drive(input logic c, input logic a0, input logic a1, input logic a2,
                         input logic a3, input logic lh);
        clr = c; lda = a0; add = a1; sub = a2; out = a3; low_halt = lh;
    endtask

    // One clock: model advances on the edge with the inputs currently applied.
    task automatic tick();
        @(posedge clk);
        if (clr) begin
            m_step = 0;
            m_halt = 1'b0;
        end else if (!m_halt) begin
            if (m_step == 3 && !low_halt) m_halt = 1'b1;
            else m_step = (m_step + 1) % 6;
        end
        @(negedge clk);
        #1;
    endtask

    function automatic void addv(input string n, input logic l_lda, input logic l_add,
            input logic l_sub, input logic l_out, input logic l_lh, input logic [5:0] et,
            input logic eh, input logic [11:0] ea_);
        vec_t v;
        v.name = n; v.clr = 1'b0; v.lda = l_lda; v.add = l_add; v.sub = l_sub;
        v.out = l_out; v.low_halt = l_lh; v.exp_t = et; v.exp_h = eh; v.exp_act = ea_;
        vecs.push_back(v);
    endfunction

    initial begin
        // LDA
        addv("lda_t1", 1,0,0,0,1, 6'h01, 0, m(A_EP, A_LM));
        addv("lda_t2", 1,0,0,0,1, 6'h02, 0, m(A_CP));
        addv("lda_t3", 1,0,0,0,1, 6'h04, 0, m(A_CE, A_LI));
        addv("lda_t4", 1,0,0,0,1, 6'h08, 0, m(A_EI, A_LM));
        addv("lda_t5", 1,0,0,0,1, 6'h10, 0, m(A_CE, A_LA));
        addv("lda_t6", 1,0,0,0,1, 6'h20, 0, '0);
        // SUB then ADD back to back
        addv("sub_t1", 0,0,1,0,1, 6'h01, 0, m(A_EP, A_LM));
        addv("sub_t2", 0,0,1,0,1, 6'h02, 0, m(A_CP));
        addv("sub_t3", 0,0,1,0,1, 6'h04, 0, m(A_CE, A_LI));
        addv("sub_t4", 0,0,1,0,1, 6'h08, 0, m(A_EI, A_LM));
        addv("sub_t5", 0,0,1,0,1, 6'h10, 0, m(A_CE, A_LB));
        addv("sub_t6", 0,0,1,0,1, 6'h20, 0, m(A_EU, A_LA, A_SU));
        addv("add_t1", 0,1,0,0,1, 6'h01, 0, m(A_EP, A_LM));
        addv("add_t2", 0,1,0,0,1, 6'h02, 0, m(A_CP));
        addv("add_t3", 0,1,0,0,1, 6'h04, 0, m(A_CE, A_LI));
        addv("add_t4", 0,1,0,0,1, 6'h08, 0, m(A_EI, A_LM));
        addv("add_t5", 0,1,0,0,1, 6'h10, 0, m(A_CE, A_LB));
        addv("add_t6", 0,1,0,0,1, 6'h20, 0, m(A_EU, A_LA));
        // OUT
        addv("out_t1", 0,0,0,1,1, 6'h01, 0, m(A_EP, A_LM));
        addv("out_t2", 0,0,0,1,1, 6'h02, 0, m(A_CP));
        addv("out_t3", 0,0,0,1,1, 6'h04, 0, m(A_CE, A_LI));
        addv("out_t4", 0,0,0,1,1, 6'h08, 0, m(A_EA, A_LO));
        addv("out_t5", 0,0,0,1,1, 6'h10, 0, '0);
        addv("out_t6", 0,0,0,1,1, 6'h20, 0, '0);
        // Undefined opcode
        addv("nop_t1", 0,0,0,0,1, 6'h01, 0, m(A_EP, A_LM));
        addv("nop_t2", 0,0,0,0,1, 6'h02, 0, m(A_CP));
        addv("nop_t3", 0,0,0,0,1, 6'h04, 0, m(A_CE, A_LI));
        addv("nop_t4", 0,0,0,0,1, 6'h08, 0, '0);
        addv("nop_t5", 0,0,0,0,1, 6'h10, 0, '0);
        addv("nop_t6", 0,0,0,0,1, 6'h20, 0, '0);
        // Priority: halt beats lda in T4; lda beats add/sub/out
        addv("pri_t1", 1,1,1,1,1, 6'h01, 0, m(A_EP, A_LM));
        addv("pri_t2", 1,1,1,1,1, 6'h02, 0, m(A_CP));
        addv("pri_t3", 1,1,1,1,1, 6'h04, 0, m(A_CE, A_LI));
        addv("pri_t4", 1,1,1,1,1, 6'h08, 0, m(A_EI, A_LM));
        addv("pri_t5", 1,1,1,1,1, 6'h10, 0, m(A_CE, A_LA));
        addv("pri_t6", 0,1,1,1,1, 6'h20, 0, m(A_EU, A_LA));
        // HLT held from T1: ignored until T4
        addv("hlt_t1", 0,0,0,0,0, 6'h01, 0, m(A_EP, A_LM));
        addv("hlt_t2", 0,0,0,0,0, 6'h02, 0, m(A_CP));
        addv("hlt_t3", 0,0,0,0,0, 6'h04, 0, m(A_CE, A_LI));
        addv("hlt_t4", 1,0,0,0,0, 6'h08, 0, '0);

        drive(1, 0, 0, 0, 0, 1);
        @(negedge clk);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        check("reset", 6'h01, 1'b0, m(A_EP, A_LM));

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].lda, vecs[i].add, vecs[i].sub, vecs[i].out,
                  vecs[i].low_halt);
            #1;
            check(vecs[i].name, vecs[i].exp_t, vecs[i].exp_h, vecs[i].exp_act);
            tick();
        end

        // Frozen for 20 clocks regardless of inputs
        for (int i = 0; i < 20; i++) begin
            drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            check("halted_hold", 6'h08, 1'b1, '0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        check("halt_clr", 6'h01, 1'b0, m(A_EP, A_LM));

        // clr in ADD T5 abandons the load of B
        drive(0, 0, 1, 0, 0, 1);
        repeat (4) tick();
        check("clr_t5_pre", 6'h10, 1'b0, m(A_CE, A_LB));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        check("clr_t5_post", 6'h01, 1'b0, m(A_EP, A_LM));

        // clr and HLT on the same T4 edge
        repeat (3) tick();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        check("clr_vs_hlt", 6'h01, 1'b0, m(A_EP, A_LM));

        // Randomized run against the reference model
        drive(1, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 2) == 0), ($urandom_range(0, 29) != 0));
            #1;
            check("random", 6'b1 << m_step, m_halt,
                  model_act(m_step, m_halt, lda, add, sub, out, low_halt));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
